// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding, read-during-write modes and width helper for ram_clr
package ram_pkg;
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;
  localparam int RDW_HOLD = 0;
  localparam int RDW_THROUGH = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: reset-driven clear sequencer, zeroes one word per cycle then releases the port
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W:0]   clr_addr
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  state_t state, state_n;
  logic [ADDR_W:0] addr_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_n;
      clr_addr <= addr_n;
    end
  end
  always_comb begin
    state_n = (state == ST_CLEAR && clr_addr == LAST) ? ST_READY : state;
    addr_n  = (state == ST_CLEAR) ? clr_addr + 1'b1 : clr_addr;
  end
  assign busy   = (state == ST_CLEAR);
  assign clr_we = busy & ~rst;
endmodule

// File: rtl/ram_clr.sv
// ram_clr: single-port synchronous RAM with clear-on-reset, status pulses and range protection
module ram_clr
  import ram_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int RDW_MODE = RDW_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  output logic              busy,
  output logic              err
);
  if (DEPTH < 2 || clog2(DEPTH) > ADDR_W) begin : g_bad_depth
    $error("ram_clr: DEPTH must be 2..2**ADDR_W");
  end
  localparam logic THROUGH = (RDW_MODE == RDW_THROUGH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W:0]   clr_addr;
  logic              in_range, live;
  ram_clr_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
  assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  assign live     = en & ~busy;
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr[ADDR_W-1:0]] <= '0;
    else if (live && in_range && we)
      mem[addr] <= in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= live & in_range & (~we | THROUGH);
      err   <= live & ~in_range;
      if (live)
        out <= !in_range ? '0 : !we ? mem[addr] : THROUGH ? in : out;
    end
  end
endmodule

// File: tb/tb_ram_clr.sv
// tb_ram_clr: three ram_clr instances (default, write-through, DEPTH=200) against an array model
module tb_ram_clr;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       we = 1'b0;
  logic [7:0] addr = '0;
  logic [9:0] din = '0;
  logic [9:0] o [3];
  logic       v [3];
  logic       b [3];
  logic       e [3];

  always #5 clk = ~clk;

  ram_clr d0 (.clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .in(din),
              .out(o[0]), .valid(v[0]), .busy(b[0]), .err(e[0]));
  ram_clr #(.RDW_MODE(1)) d1 (.clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .in(din),
              .out(o[1]), .valid(v[1]), .busy(b[1]), .err(e[1]));
  ram_clr #(.DEPTH(200)) d2 (.clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .in(din),
              .out(o[2]), .valid(v[2]), .busy(b[2]), .err(e[2]));

  int mm [3][256];
  int dep [3] = '{256, 256, 200};
  int rdw [3] = '{0, 1, 0};
  int mo [3];
  int mv [3];
  int me [3];
  int ml [3];
  int pass_n = 0;
  int tot_n = 0;

  typedef struct {
    logic en;
    logic we;
    int   a;
    int   d;
    int   eo;
    int   ev;
  } vec_t;
  vec_t tv [14];

  task automatic chk(input string nm, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Memory is modelled as zeroed at reset: user writes are locked out until the clear finishes.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0;
      me[i] = 0;
      if (rst) begin
        ml[i] = dep[i];
        mo[i] = 0;
        for (int k = 0; k < 256; k++) mm[i][k] = 0;
      end else if (ml[i] > 0) begin
        ml[i]--;
      end else if (en) begin
        if (int'(addr) >= dep[i]) begin
          mo[i] = 0;
          me[i] = 1;
        end else if (we) begin
          mm[i][addr] = int'(din);
          if (rdw[i] == 1) begin
            mo[i] = int'(din);
            mv[i] = 1;
          end
        end else begin
          mo[i] = mm[i][addr];
          mv[i] = 1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic en_i, input logic we_i, input int a, input int d);
    rst = r;
    en = en_i;
    we = we_i;
    addr = a[7:0];
    din = d[9:0];
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d.out", i), int'(o[i]), mo[i]);
      chk($sformatf("d%0d.valid", i), int'(v[i]), mv[i]);
      chk($sformatf("d%0d.err", i), int'(e[i]), me[i]);
      chk($sformatf("d%0d.busy", i), int'(b[i]), int'(ml[i] > 0));
    end
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (b[0] && n < 2000) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
  endtask

  initial begin
    int n;
    tv = '{
      '{1, 0, 1,   0,   0,   1},
      '{1, 0, 200, 0,   0,   1},
      '{1, 0, 255, 0,   0,   1},
      '{1, 1, 1,   5,   0,   0},
      '{1, 1, 3,   60,  0,   0},
      '{1, 1, 15,  100, 0,   0},
      '{1, 1, 200, 420, 0,   0},
      '{1, 0, 1,   0,   5,   1},
      '{1, 0, 3,   0,   60,  1},
      '{1, 0, 15,  0,   100, 1},
      '{1, 0, 68,  0,   0,   1},
      '{1, 0, 200, 0,   420, 1},
      '{0, 0, 200, 0,   420, 0},
      '{1, 1, 68,  999, 420, 0}
    };
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset.out", int'(o[0]), 0);
    chk("reset.busy", int'(b[0]), 1);
    wait_clear(n);
    chk("busy_len", n, 256);
    for (int t = 0; t < 14; t++) begin
      step(0, tv[t].en, tv[t].we, tv[t].a, tv[t].d);
      chk($sformatf("vec%0d.out", t), int'(o[0]), tv[t].eo);
      chk($sformatf("vec%0d.valid", t), int'(v[0]), tv[t].ev);
    end
    step(0, 1, 1, 9, 77);
    chk("rdw.out", int'(o[1]), 77);
    chk("rdw.valid", int'(v[1]), 1);
    step(0, 1, 0, 9, 0);
    chk("rdw.read", int'(o[1]), 77);
    step(0, 1, 1, 210, 33);
    chk("oor.err", int'(e[2]), 1);
    chk("oor.out", int'(o[2]), 0);
    step(0, 0, 0, 0, 0);
    chk("oor.err_drop", int'(e[2]), 0);
    step(0, 1, 1, 199, 33);
    step(0, 1, 0, 199, 0);
    chk("d200.read", int'(o[2]), 33);
    step(1, 0, 0, 0, 0);
    for (int t = 0; t < 20; t++) step(0, 1, 1, 4, 9);
    wait_clear(n);
    step(0, 1, 0, 4, 0);
    chk("busy_wr.read", int'(o[0]), 0);
    chk("busy_wr.valid", int'(v[0]), 1);
    step(0, 1, 1, 7, 123);
    step(1, 0, 0, 0, 0);
    for (int t = 0; t < 50; t++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    wait_clear(n);
    chk("restart_len", n, 256);
    step(0, 1, 0, 7, 0);
    chk("restart.read", int'(o[0]), 0);
    for (int t = 0; t < 600; t++)
      step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)));
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/ram_clr.md
Name: ram_clr

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 256x10 RAM.
- Adds:
  - a reset-driven clear sequencer that zeroes every word, one per cycle;
  - busy, valid and err status outputs;
  - a selectable read-during-write mode;
  - out-of-range address protection for non-power-of-two depths.
- Sits as scratch/data storage behind the lab datapath controllers.

Parameters:
- DATA_W, 10, word width in bits
- DEPTH, 256, number of words; any value 2..2^ADDR_W
- ADDR_W, 8, address width; must satisfy DEPTH <= 2^ADDR_W
- RDW_MODE, 0, write behaviour of out: 0 = out holds its value on writes, 1 = write-through (out <= in)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset; starts the memory clear
- en  input  1  access enable
- we  input  1  write enable; qualified by en
- addr  input  ADDR_W  word address
- in  input  DATA_W  write data
- out  output  DATA_W  registered read data
- valid  output  1  one-cycle pulse; out was updated by an accepted read
- busy  output  1  high while clearing; accesses are ignored
- err  output  1  one-cycle pulse; an access targeted addr >= DEPTH

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). No other clock or reset.
- Clock edge with rst=1, regardless of state:
  - state <= CLEAR, clr_addr <= 0
  - out <= 0, valid <= 0, err <= 0, busy <= 1
- States:
  - CLEAR, encoded 1'b0, also the reset state
  - READY, encoded 1'b1
- CLEAR, on each edge with rst=0:
  - mem[clr_addr] <= 0, then clr_addr++.
  - On the edge that writes DEPTH-1: state <= READY, busy <= 0.
  - busy therefore falls on the DEPTH-th edge after rst is deasserted.
  - en, we, addr and in are ignored. out holds 0; valid and err stay 0.
- rst asserted mid-clear restarts the clear at address 0.
- READY access rules, evaluated at the clock edge:
  - en=0: nothing changes; out holds; valid=0; err=0.
  - en=1, we=1, addr<DEPTH: mem[addr] <= in. RDW_MODE=0: out holds, valid=0. RDW_MODE=1: out <= in, valid=1.
  - en=1, we=0, addr<DEPTH: out <= mem[addr]; valid=1 in the following cycle. Read latency is exactly 1 cycle.
  - en=1, addr>=DEPTH: memory is untouched; out <= 0; valid=0; err=1 for one cycle.
- valid and err are registered and remain high for exactly one cycle per accepted access. Back-to-back accesses keep them asserted continuously.
- Read after write to the same address on the next cycle returns the new data; no forwarding logic is needed.
- Memory contents persist across en=0 periods. Only rst clears them.
- The clear counter is ADDR_W+1 bits wide so that DEPTH = 2^ADDR_W terminates without wrap ambiguity.

Decomposition:
- ram_pkg holds:
  - the state encoding localparams ST_CLEAR and ST_READY;
  - RDW_HOLD = 0 and RDW_THROUGH = 1;
  - a clog2 function used to check ADDR_W.
- One sub-module, ram_clr_seq: the CLEAR/READY FSM plus the clr_addr counter. It outputs busy, clr_we and clr_addr.
- The top level holds the storage array, the write/read muxing between the sequencer and the user port, and the out/valid/err registers.

Test Plan:
- rst=1 for 2 cycles, then 0 → busy=1 for exactly 256 cycles, then 0. A read of addr 1, 200 and 255 afterwards returns 0 each, with a valid pulse each.
- Defaults, RDW_MODE=0: write 5@1, 60@3, 100@15, 420@200; then read 1, 3, 15, 200, 68 → out = 5, 60, 100, 420, 0, each one cycle after its read, with valid=1. out is unchanged during the writes.
- RDW_MODE=1: write 77@9 → out=77 with valid=1 on the next cycle. A read of 9 on the following cycle → 77.
- DEPTH=200 instance: write 33@210 → err pulses once, out=0. Write 33@199, then read 199 → out=33.
- en=1, we=1 with addr 4, in 9 during busy=1 → no effect: a read of addr 4 after busy falls returns 0.
- Write 123@7, then assert rst at clear cycle 50 → clear restarts and busy stays high for 256 more cycles. A read of 7 afterwards returns 0.
